// File: rtl/eth_packet_arbiter_pkg.sv
// rtl/eth_packet_arbiter_pkg.sv - shared request levels, FSM encoding and helpers for the packet arbiter
package eth_packet_arbiter_pkg;

    localparam logic [1:0] REQ_NONE = 2'd0;
    localparam logic [1:0] REQ_LOW  = 2'd1;
    localparam logic [1:0] REQ_MID  = 2'd2;
    localparam logic [1:0] REQ_HIGH = 2'd3;

    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_EMPTY_WIDTH = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_packet_arbiter_pick.sv
// rtl/eth_packet_arbiter_pick.sv - combinational level-then-round-robin winner picker
module pkt_arb_pick
    import eth_packet_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [2*NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0]   mask_i,
    input  logic [PTR_W-1:0]       rr_ptr_i,
    output logic [PTR_W-1:0]       winner_o,
    output logic                   any_valid_o
);

    logic [1:0] best_lvl;
    logic [1:0] lvl;
    int         idx;

    // Walking in rotated order and only replacing on a strictly higher level
    // leaves the first port at or after rr_ptr among the highest-level requesters.
    always_comb begin
        best_lvl    = REQ_NONE;
        lvl         = REQ_NONE;
        idx         = 0;
        winner_o    = '0;
        any_valid_o = 1'b0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            idx = int'(rr_ptr_i) + off;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            lvl = req_i[idx*2 +: 2];
            if (!mask_i[idx] && (lvl > best_lvl)) begin
                best_lvl    = lvl;
                winner_o    = PTR_W'(idx);
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_packet_arbiter.sv
// rtl/eth_packet_arbiter.sv - grants packet sources by level/round-robin and merges their beats onto one stream
module eth_packet_arbiter
    import eth_packet_arbiter_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int EMPTY_WIDTH   = DEF_EMPTY_WIDTH,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [2*NUM_PORTS-1:0]           in_request,
    output logic [NUM_PORTS-1:0]             in_grant,
    input  logic [NUM_PORTS-1:0]             in_packet_eop,
    output logic [NUM_PORTS-1:0]             in_ready,
    input  logic [NUM_PORTS-1:0]             in_valid,
    input  logic [NUM_PORTS-1:0]             in_sop,
    input  logic [NUM_PORTS-1:0]             in_eop,
    input  logic [NUM_PORTS-1:0]             in_error,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0]  in_data,
    input  logic [EMPTY_WIDTH*NUM_PORTS-1:0] in_empty,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic                             out_sop,
    output logic                             out_eop,
    output logic                             out_error,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [EMPTY_WIDTH-1:0]           out_empty,
    output logic [15:0]                      collision_cnt,
    output logic [15:0]                      timeout_cnt
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TMO_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

    arb_state_t             state_q;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [15:0]            coll_cnt_q;
    logic [15:0]            tmo_cnt_q;

    logic [NUM_PORTS-1:0]   pick_mask;
    logic [PTR_W-1:0]       winner;
    logic                   any_req;
    logic [PTR_W-1:0]       rr_next;
    logic                   owner_eop;
    logic                   tmo_hit;

    // While owned, the current owner is excluded so an eop hands over to someone else.
    assign pick_mask = (state_q == ARB_OWNED) ? grant_q : '0;
    assign owner_eop = |(in_packet_eop & grant_q);
    assign tmo_hit   = (tmo_q == TMO_W'(GRANT_TIMEOUT - 1));
    assign rr_next   = (winner == PTR_W'(NUM_PORTS - 1)) ? '0 : winner + PTR_W'(1);

    pkt_arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req_i       (in_request),
        .mask_i      (pick_mask),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (winner),
        .any_valid_o (any_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            tmo_q     <= '0;
            tmo_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_q  <= NUM_PORTS'(1) << winner;
                        rr_ptr_q <= rr_next;
                        tmo_q    <= '0;
                        state_q  <= ARB_OWNED;
                    end
                end
                ARB_OWNED: begin
                    if (owner_eop) begin
                        if (any_req) begin
                            grant_q  <= NUM_PORTS'(1) << winner;
                            rr_ptr_q <= rr_next;
                            tmo_q    <= '0;
                        end else begin
                            grant_q <= '0;
                            state_q <= ARB_IDLE;
                        end
                    end else if (tmo_hit) begin
                        grant_q   <= '0;
                        tmo_cnt_q <= sat_inc16(tmo_cnt_q);
                        state_q   <= ARB_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    logic                   valid_d, sop_d, eop_d, error_d, coll_d;
    logic [DATA_WIDTH-1:0]  data_d;
    logic [EMPTY_WIDTH-1:0] empty_d;
    logic                   valid_q, sop_q, eop_q, error_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [EMPTY_WIDTH-1:0] empty_q;

    // Datapath ignores the grant: lowest valid index wins, extra valids flag a collision.
    always_comb begin
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        error_d = 1'b0;
        coll_d  = 1'b0;
        data_d  = '0;
        empty_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (in_valid[i]) begin
                if (!valid_d) begin
                    sop_d   = in_sop[i];
                    eop_d   = in_eop[i];
                    error_d = in_error[i];
                    data_d  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                    empty_d = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
                end else begin
                    coll_d = 1'b1;
                end
                valid_d = 1'b1;
            end
        end
        if (coll_d) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            error_q    <= 1'b0;
            data_q     <= '0;
            empty_q    <= '0;
            coll_cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            error_q <= error_d;
            data_q  <= data_d;
            empty_q <= empty_d;
            if (coll_d) begin
                coll_cnt_q <= sat_inc16(coll_cnt_q);
            end
        end
    end

    assign in_grant      = grant_q;
    assign in_ready      = {NUM_PORTS{out_ready}};
    assign out_valid     = valid_q;
    assign out_sop       = sop_q;
    assign out_eop       = eop_q;
    assign out_error     = error_q;
    assign out_data      = data_q;
    assign out_empty     = empty_q;
    assign collision_cnt = coll_cnt_q;
    assign timeout_cnt   = tmo_cnt_q;

endmodule

// File: tb/tb_eth_packet_arbiter.sv
// tb/tb_eth_packet_arbiter.sv - scoreboard bench for eth_packet_arbiter
module tb_eth_packet_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int EW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2*NP-1:0]   in_request;
    logic [NP-1:0]     in_grant;
    logic [NP-1:0]     in_packet_eop;
    logic [NP-1:0]     in_ready;
    logic [NP-1:0]     in_valid, in_sop, in_eop, in_error;
    logic [DW*NP-1:0]  in_data;
    logic [EW*NP-1:0]  in_empty;
    logic              out_ready;
    logic              out_valid, out_sop, out_eop, out_error;
    logic [DW-1:0]     out_data;
    logic [EW-1:0]     out_empty;
    logic [15:0]       collision_cnt, timeout_cnt;

    eth_packet_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .GRANT_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_request(in_request), .in_grant(in_grant),
        .in_packet_eop(in_packet_eop), .in_ready(in_ready), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .in_error(in_error), .in_data(in_data),
        .in_empty(in_empty), .out_ready(out_ready), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error),
        .out_data(out_data), .out_empty(out_empty),
        .collision_cnt(collision_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sig;
        logic [63:0] exp;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
        logic          err;
    } beat_t;

    exp_t  sig_q[$];
    beat_t beat_q[$];
    int    checks   = 0;
    int    failures = 0;

    localparam int S_GRANT = 0, S_COLL = 1, S_TMO = 2, S_VALID = 3, S_READY = 4, S_PEND = 5;

    function automatic string sig_name(input int s);
        case (s)
            S_GRANT: return "in_grant";
            S_COLL:  return "collision_cnt";
            S_TMO:   return "timeout_cnt";
            S_VALID: return "out_valid";
            S_READY: return "in_ready";
            default: return "beats_pending";
        endcase
    endfunction

    function automatic logic [63:0] sig_val(input int s);
        case (s)
            S_GRANT: return 64'(in_grant);
            S_COLL:  return 64'(collision_cnt);
            S_TMO:   return 64'(timeout_cnt);
            S_VALID: return 64'(out_valid);
            S_READY: return 64'(in_ready);
            default: return 64'(beat_q.size());
        endcase
    endfunction

    // Monitor: the only process that compares and steps the counters.
    always @(negedge clk) begin
        exp_t        e;
        beat_t       b;
        logic [63:0] act;
        while (sig_q.size() > 0) begin
            e   = sig_q.pop_front();
            act = sig_val(e.sig);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s actual=%0h required=%0h @%0t", sig_name(e.sig), act, e.exp, $time);
            end
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (beat_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat actual data=%0h required=no beat @%0t", out_data, $time);
            end else begin
                b = beat_q.pop_front();
                if (out_data !== b.data || out_empty !== b.empty || out_sop !== b.sop ||
                    out_eop !== b.eop || out_error !== b.err) begin
                    failures++;
                    $display("FAIL beat actual data=%0h emp=%0d sop=%b eop=%b err=%b required data=%0h emp=%0d sop=%b eop=%b err=%b @%0t",
                             out_data, out_empty, out_sop, out_eop, out_error,
                             b.data, b.empty, b.sop, b.eop, b.err, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int s, input logic [63:0] v);
        exp_t e;
        e.sig = s;
        e.exp = v;
        sig_q.push_back(e);
    endtask

    task automatic clear_beats();
        in_valid = '0; in_sop = '0; in_eop = '0; in_error = '0;
        in_data  = '0; in_empty = '0;
    endtask

    task automatic set_req(input int p, input logic [1:0] lvl);
        in_request[p*2 +: 2] = lvl;
    endtask

    task automatic put_beat(input int p, input logic [DW-1:0] d, input logic s, input logic e,
                            input logic er, input logic [EW-1:0] em);
        in_valid[p]           = 1'b1;
        in_sop[p]             = s;
        in_eop[p]             = e;
        in_error[p]           = er;
        in_data[p*DW +: DW]   = d;
        in_empty[p*EW +: EW]  = em;
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic s, input logic e,
                             input logic er, input logic [EW-1:0] em);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e; b.err = er; b.empty = em;
        beat_q.push_back(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_request = '0; in_packet_eop = '0;
        clear_beats();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        out_ready = 1'b1;
        do_reset();
        expect_sig(S_GRANT, 0); expect_sig(S_VALID, 0);
        expect_sig(S_COLL, 0);  expect_sig(S_TMO, 0);
        expect_sig(S_READY, 64'hF);
        tick();
        out_ready = 1'b0;
        #1 expect_sig(S_READY, 0);
        tick();
        out_ready = 1'b1;

        // 1: single high-priority source, 5-beat packet, early release at beat 2
        set_req(0, 2'd3);
        tick();
        expect_sig(S_GRANT, 64'h1);
        for (int k = 0; k < 5; k++) begin
            clear_beats();
            put_beat(0, 64'hA000 + 64'(k), k == 0, k == 4, 1'b0, (k == 4) ? 3'd5 : 3'd0);
            push_beat(64'hA000 + 64'(k), k == 0, k == 4, 1'b0, (k == 4) ? 3'd5 : 3'd0);
            in_packet_eop = (k == 2) ? 4'b0001 : 4'b0000;
            if (k == 2) set_req(0, 2'd0);
            tick();
            if (k == 2) expect_sig(S_GRANT, 0);
        end
        clear_beats();
        in_packet_eop = '0;
        tick();
        expect_sig(S_VALID, 0);
        expect_sig(S_PEND, 0);

        // 2: equal low requests on ports 1 and 2, handover without idle cycle
        do_reset();
        set_req(1, 2'd1); set_req(2, 2'd1);
        tick();
        expect_sig(S_GRANT, 64'h2);
        in_packet_eop = 4'b0100;
        tick();
        expect_sig(S_GRANT, 64'h2);
        in_packet_eop = 4'b0010; set_req(1, 2'd0);
        tick();
        expect_sig(S_GRANT, 64'h4);
        in_packet_eop = 4'b0100; set_req(2, 2'd0);
        tick();
        expect_sig(S_GRANT, 0);
        in_packet_eop = '0;

        // 3: high level beats lower index
        do_reset();
        set_req(0, 2'd1); set_req(3, 2'd3);
        tick();
        expect_sig(S_GRANT, 64'h8);
        in_packet_eop = 4'b1000; set_req(3, 2'd0);
        tick();
        expect_sig(S_GRANT, 64'h1);
        in_packet_eop = 4'b0001; set_req(0, 2'd0);
        tick();
        expect_sig(S_GRANT, 0);
        in_packet_eop = '0;

        // 4: grant held without eop is forced off after 64 cycles
        do_reset();
        set_req(1, 2'd2);
        tick();
        expect_sig(S_GRANT, 64'h2);
        repeat (63) tick();
        expect_sig(S_GRANT, 64'h2);
        expect_sig(S_TMO, 0);
        set_req(1, 2'd0);
        tick();
        expect_sig(S_GRANT, 0);
        expect_sig(S_TMO, 1);
        tick();
        expect_sig(S_GRANT, 0);

        // 5: simultaneous valids forward lowest index with error, then port 2 alone
        do_reset();
        put_beat(0, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 1'b0, 3'd2);
        put_beat(2, 64'h5555_6666_7777_8888, 1'b1, 1'b1, 1'b0, 3'd7);
        push_beat(64'h1111_2222_3333_4444, 1'b1, 1'b1, 1'b1, 3'd2);
        tick();
        clear_beats();
        put_beat(2, 64'h5555_6666_7777_8888, 1'b1, 1'b0, 1'b0, 3'd7);
        push_beat(64'h5555_6666_7777_8888, 1'b1, 1'b0, 1'b0, 3'd7);
        tick();
        expect_sig(S_COLL, 1);
        clear_beats();
        tick();
        expect_sig(S_VALID, 0);
        expect_sig(S_PEND, 0);

        // 6: reset during beat 2 drops the partial packet and clears everything
        do_reset();
        put_beat(1, 64'hC0, 1'b0, 1'b0, 1'b0, 3'd0);
        put_beat(3, 64'hC3, 1'b0, 1'b0, 1'b0, 3'd0);
        push_beat(64'hC0, 1'b0, 1'b0, 1'b1, 3'd0);
        tick();
        clear_beats();
        set_req(0, 2'd3);
        tick();
        expect_sig(S_COLL, 1);
        expect_sig(S_GRANT, 64'h1);
        for (int k = 0; k < 2; k++) begin
            clear_beats();
            put_beat(0, 64'hD0 + 64'(k), k == 0, 1'b0, 1'b0, 3'd0);
            push_beat(64'hD0 + 64'(k), k == 0, 1'b0, 1'b0, 3'd0);
            tick();
        end
        clear_beats();
        put_beat(0, 64'hD2, 1'b0, 1'b0, 1'b0, 3'd0);
        rst_n = 1'b0;
        tick();
        expect_sig(S_GRANT, 0); expect_sig(S_VALID, 0);
        expect_sig(S_COLL, 0);  expect_sig(S_TMO, 0);
        expect_sig(S_PEND, 0);
        rst_n = 1'b1;
        clear_beats();
        in_request = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
